// File: rtl/key_event_encoder.sv
// Five-key debouncer that turns accepted level changes into press/release
// events queued in a small show-ahead FIFO with a sticky overflow flag.
module key_event_encoder #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_up,
    input  logic       key_down,
    input  logic       key_left,
    input  logic       key_right,
    input  logic       key_z,
    input  logic       ev_ready,
    input  logic       ovf_clr,
    output logic       ev_valid,
    output logic [3:0] ev_code,
    output logic [4:0] key_state,
    output logic       ev_overflow
);

    localparam int              CW  = 20;
    localparam logic [CW-1:0]   LIM = CW'(DEBOUNCE_CYCLES - 1);

    logic [4:0]    w_raw;
    logic [4:0]    r_sync1;
    logic [4:0]    r_sync2;
    logic [4:0]    w_level;
    logic [4:0]    w_diff;
    logic [4:0]    w_hit;
    logic [CW-1:0] r_cnt [5];
    logic [4:0]    r_key_state;
    logic [4:0]    r_pend;

    logic [4:0]    w_sel;
    logic [2:0]    w_id;
    logic          w_push;
    logic [3:0]    w_push_code;

    logic [3:0]    r_mem [4];
    logic [1:0]    r_wptr;
    logic [1:0]    r_rptr;
    logic [2:0]    r_count;
    logic          r_ovf;
    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_wr;
    logic          w_drop;

    assign w_raw = {key_z, key_right, key_left, key_down, key_up};

    // Two-flop synchronizer; idle level is released (high)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 5'h1f;
            r_sync2 <= 5'h1f;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

    assign w_level = ~r_sync2;
    assign w_diff  = w_level ^ r_key_state;

    // A key flips on the cycle its counter is saturated and still differs
    always_comb begin
        w_hit = '0;
        for (int i = 0; i < 5; i++) begin
            w_hit[i] = w_diff[i] && (r_cnt[i] == LIM);
        end
    end

    // Per-key stability counters, cleared whenever the level agrees
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 5; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 5; i++) begin
                if (!w_diff[i] || w_hit[i]) begin
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CW'(1);
                end
            end
        end
    end

    // Debounced key levels
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_key_state <= '0;
        end else begin
            r_key_state <= r_key_state ^ w_hit;
        end
    end

    // Pick one pending key per cycle: z first, then up, down, left, right
    always_comb begin
        w_sel = 5'b00000;
        w_id  = 3'd0;
        if (r_pend[4]) begin
            w_sel = 5'b10000;
            w_id  = 3'd4;
        end else if (r_pend[0]) begin
            w_sel = 5'b00001;
            w_id  = 3'd0;
        end else if (r_pend[1]) begin
            w_sel = 5'b00010;
            w_id  = 3'd1;
        end else if (r_pend[2]) begin
            w_sel = 5'b00100;
            w_id  = 3'd2;
        end else if (r_pend[3]) begin
            w_sel = 5'b01000;
            w_id  = 3'd3;
        end
    end

    assign w_push      = |r_pend;
    assign w_push_code = {|(r_key_state & w_sel), w_id};

    // Pending flags: a fresh toggle outranks the clear of a written key
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pend <= '0;
        end else begin
            r_pend <= (r_pend & ~w_sel) | w_hit;
        end
    end

    assign w_empty = (r_count == 3'd0);
    assign w_full  = (r_count == 3'd4);
    assign w_pop   = !w_empty && ev_ready;
    assign w_wr    = w_push && (!w_full || w_pop);
    assign w_drop  = w_push && w_full && !w_pop;

    // FIFO storage and write pointer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                r_mem[i] <= 4'b0000;
            end
            r_wptr <= 2'd0;
        end else if (w_wr) begin
            r_mem[r_wptr] <= w_push_code;
            r_wptr        <= r_wptr + 2'd1;
        end
    end

    // FIFO read pointer and occupancy
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rptr  <= 2'd0;
            r_count <= 3'd0;
        end else begin
            if (w_pop) begin
                r_rptr <= r_rptr + 2'd1;
            end
            if (w_wr && !w_pop) begin
                r_count <= r_count + 3'd1;
            end else if (w_pop && !w_wr) begin
                r_count <= r_count - 3'd1;
            end
        end
    end

    // Sticky overflow; a new drop beats a simultaneous clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

    assign ev_valid    = !w_empty;
    assign ev_code     = w_empty ? 4'b0000 : r_mem[r_rptr];
    assign key_state   = r_key_state;
    assign ev_overflow = r_ovf;

endmodule

// File: tb/tb_key_event_encoder.sv
// Bench for key_event_encoder: directed scenarios plus random key activity
// compared every cycle against a queue-based behavioural model.
module tb_key_event_encoder;

    localparam int N = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] raw;
    logic       ready;
    logic       clr;
    logic       ev_valid;
    logic [3:0] ev_code;
    logic [4:0] key_state;
    logic       ev_overflow;

    int total = 0;
    int bad   = 0;

    // model state
    logic [4:0] m_s1, m_s2, m_state, m_pend;
    int         m_run [5];
    logic [3:0] m_q [$];
    logic       m_ovf;
    int         prio [5] = '{4, 0, 1, 2, 3};

    key_event_encoder #(.DEBOUNCE_CYCLES(N)) dut (
        .clk        (clk),
        .reset      (rst),
        .key_up     (raw[0]),
        .key_down   (raw[1]),
        .key_left   (raw[2]),
        .key_right  (raw[3]),
        .key_z      (raw[4]),
        .ev_ready   (ready),
        .ovf_clr    (clr),
        .ev_valid   (ev_valid),
        .ev_code    (ev_code),
        .key_state  (key_state),
        .ev_overflow(ev_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_s1    = 5'h1f;
        m_s2    = 5'h1f;
        m_state = '0;
        m_pend  = '0;
        m_ovf   = 1'b0;
        m_q.delete();
        for (int i = 0; i < 5; i++) m_run[i] = 0;
    endtask

    task automatic model_update();
        logic [4:0] old_state;
        logic [4:0] old_pend;
        logic [4:0] old_s2;
        logic       drop;
        int         k;
        if (!rst) begin
            model_reset();
            return;
        end
        old_state = m_state;
        old_pend  = m_pend;
        old_s2    = m_s2;
        drop      = 1'b0;
        if (m_q.size() != 0 && ready) void'(m_q.pop_front());
        if (old_pend != 0) begin
            k = -1;
            for (int p = 0; p < 5; p++)
                if (k < 0 && old_pend[prio[p]]) k = prio[p];
            m_pend[k] = 1'b0;
            if (m_q.size() < 4) m_q.push_back({old_state[k], 3'(k)});
            else drop = 1'b1;
        end
        if (drop) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if ((!old_s2[i]) != old_state[i]) begin
                m_run[i]++;
                if (m_run[i] == N) begin
                    m_state[i] = ~m_state[i];
                    m_pend[i]  = 1'b1;
                    m_run[i]   = 0;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        m_s2 = m_s1;
        m_s1 = raw;
    endtask

    task automatic check_model();
        check("valid", ev_valid, m_q.size() != 0);
        check("code", ev_code, (m_q.size() != 0) ? m_q[0] : 4'b0000);
        check("state", key_state, m_state);
        check("ovf", ev_overflow, m_ovf);
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
        check_model();
    endtask

    initial begin
        rst   = 1'b0;
        raw   = 5'h1f;
        ready = 1'b0;
        clr   = 1'b0;
        model_reset();
        repeat (3) tick();
        check("rst_valid", ev_valid, 0);
        check("rst_code", ev_code, 0);
        check("rst_state", key_state, 0);
        check("rst_ovf", ev_overflow, 0);
        rst = 1'b1;
        repeat (3) tick();

        // single press with latency
        raw[0] = 1'b0;
        for (int e = 1; e <= 11; e++) begin
            tick();
            if (e == 9)  check("up_state_e9", key_state, 5'h00);
            if (e == 10) check("up_state_e10", key_state, 5'h01);
            if (e == 10) check("up_valid_e10", ev_valid, 0);
            if (e == 11) check("up_valid_e11", ev_valid, 1);
            if (e == 11) check("up_code_e11", ev_code, 4'b1000);
        end
        ready = 1'b1;
        tick();
        check("up_popped", ev_valid, 0);
        raw[0] = 1'b1;
        repeat (14) tick();

        // short bounce
        raw[2] = 1'b0;
        repeat (5) tick();
        raw[2] = 1'b1;
        repeat (15) tick();
        check("bounce_state", key_state, 5'h00);
        check("bounce_valid", ev_valid, 0);

        // simultaneous presses, priority order
        raw = 5'b00110;
        repeat (10) tick();
        tick();
        check("pri_code0", ev_code, 4'b1100);
        tick();
        check("pri_code1", ev_code, 4'b1000);
        tick();
        check("pri_code2", ev_code, 4'b1011);
        tick();
        check("pri_empty", ev_valid, 0);
        raw = 5'h1f;
        repeat (25) tick();

        // overflow with five events
        ready = 1'b0;
        raw   = 5'h00;
        repeat (16) tick();
        check("ovf_set", ev_overflow, 1);
        check("ovf_head", ev_code, 4'b1100);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("ovf_clr", ev_overflow, 0);

        // push into full FIFO while popping
        raw[4] = 1'b1;
        repeat (10) tick();
        ready = 1'b1;
        tick();
        ready = 1'b0;
        check("full_pp_ovf", ev_overflow, 0);
        check("full_pp_head", ev_code, 4'b1000);
        ready = 1'b1;
        tick();
        check("drain1", ev_code, 4'b1001);
        tick();
        check("drain2", ev_code, 4'b1010);
        tick();
        check("drain3", ev_code, 4'b0100);
        tick();
        check("drain_empty", ev_valid, 0);
        raw = 5'h1f;
        repeat (25) tick();

        // reset mid-debounce and mid-FIFO
        ready  = 1'b0;
        raw[0] = 1'b0;
        repeat (12) tick();
        raw[0] = 1'b1;
        raw[1] = 1'b0;
        repeat (4) tick();
        rst = 1'b0;
        model_reset();
        #1;
        check("mrst_valid", ev_valid, 0);
        check("mrst_code", ev_code, 0);
        check("mrst_state", key_state, 0);
        check("mrst_ovf", ev_overflow, 0);
        @(negedge clk);
        repeat (3) tick();
        rst = 1'b1;
        for (int e = 1; e <= 11; e++) tick();
        check("held_valid", ev_valid, 1);
        check("held_code", ev_code, 4'b1001);
        ready = 1'b1;
        tick();
        check("held_once", ev_valid, 0);
        repeat (20) tick();
        check("held_quiet", ev_valid, 0);

        // random activity
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 5; i++)
                if ($urandom_range(0, 15) == 0) raw[i] = ~raw[i];
            ready = (c % 300 < 100) ? 1'b0 : ($urandom_range(0, 3) != 0);
            clr   = ($urandom_range(0, 39) == 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
